// File: rtl/gcd_rr_scheduler.sv
// rtl/gcd_rr_scheduler.sv - round-robin front end sharing one GCD engine among NREQ requesters.
// Optional WAIT timeout/abort path enabled by defining GCD_TIMEOUT_EN.
module gcd_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_gcd,
  output logic              rsp_err,
  output logic              busy,
  output logic              eng_start,
  output logic [W-1:0]      eng_a,
  output logic [W-1:0]      eng_b,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [W-1:0]      rsp_gcd_q, rsp_gcd_d;

  logic              found;
  logic [IDW-1:0]    win;
  logic [W-1:0]      a_sel, b_sel;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin : arb
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    a_sel = a_in[int'(win)*W +: W];
    b_sel = b_in[int'(win)*W +: W];
  end

`ifdef GCD_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    grant_d   = '0;
    rsp_id_d  = rsp_id_q;
    rsp_gcd_d = rsp_gcd_q;
`ifdef GCD_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d    = win;
          a_d     = a_sel;
          b_d     = b_sel;
          grant_d = NREQ'(1) << win;
          // A zero operand would never terminate the subtract loop.
          if (a_sel == '0 || b_sel == '0) begin
            state_d   = S_RESP;
            rsp_id_d  = win;
            rsp_gcd_d = a_sel | b_sel;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef GCD_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (eng_done) begin
          state_d   = S_RESP;
          rsp_id_d  = id_q;
          rsp_gcd_d = eng_result;
        end
`ifdef GCD_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d   = S_RESP;
          rsp_id_d  = id_q;
          rsp_gcd_d = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      grant_q   <= '0;
      rsp_id_q  <= '0;
      rsp_gcd_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      grant_q   <= grant_d;
      rsp_id_q  <= rsp_id_d;
      rsp_gcd_q <= rsp_gcd_d;
    end
  end

`ifdef GCD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign grant     = grant_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_gcd   = rsp_gcd_q;
  assign busy      = (state_q != S_IDLE);
  assign eng_start = (state_q == S_ISSUE);
  assign eng_a     = a_q;
  assign eng_b     = b_q;

endmodule
